// File: rtl/motor_frame_tx.sv
// motor_frame_tx
//    Transmit framer for the four-motor speed link. On a request (send pulse
//    or optional periodic refresh tick) the four motor speeds are snapshotted
//    and sent as a 5-byte frame: HEADER, Motor1, Motor2, Motor3, Motor4, over
//    a byte-wide valid/ready handshake towards the UART transmitter.
//
// Ports
//    clk        system clock, rising edge
//    rst        synchronous reset, active high
//    send       frame request (pulse or level), sampled every cycle
//    Motor1..4  speed values, frame bytes 1..4
//    serial     current output byte, valid while out_valid=1
//    out_valid  serial holds a byte to transfer
//    out_ready  downstream accepts the byte this cycle
//    busy       frame in progress
//    done       one-cycle pulse after the final byte of a frame transfers
module motor_frame_tx #(
   parameter logic [7:0]  HEADER  = 8'hFF,
   parameter int unsigned REFRESH = 0,
   parameter int unsigned CNT_W   = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send,
   input  logic [7:0] Motor1,
   input  logic [7:0] Motor2,
   input  logic [7:0] Motor3,
   input  logic [7:0] Motor4,
   output logic [7:0] serial,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, HDR, M1, M2, M3, M4} state_t;

   state_t     state_q, state_d;
   logic [7:0] snap_q [4];
   logic [7:0] snap_d [4];
   logic [7:0] motor_in [4];
   logic       pending_q, pending_d;
   logic [7:0] serial_q, serial_d;
   logic       out_valid_q, out_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       tick;
   logic       req;
   logic       xfer;

   assign motor_in[0] = Motor1;
   assign motor_in[1] = Motor2;
   assign motor_in[2] = Motor3;
   assign motor_in[3] = Motor4;

   // Free-running refresh counter; runs regardless of frame state so the
   // auto-send period is exact. Absent entirely when REFRESH is 0.
   generate
      if (REFRESH == 0) begin : g_no_refresh
         assign tick = 1'b0;
      end else begin : g_refresh
         logic [CNT_W-1:0] cnt_q, cnt_d;
         assign tick = (cnt_q == CNT_W'(REFRESH - 1));
         always_comb begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
         end
         always_ff @(posedge clk) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
         end
      end
   endgenerate

   assign req  = send | tick;
   assign xfer = out_valid_q & out_ready;

   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      pending_d = pending_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               snap_d  = motor_in;
               state_d = HDR;
            end
         end
         HDR: begin
            if (xfer) state_d = M1;
            if (req)  pending_d = 1'b1;
         end
         M1: begin
            if (xfer) state_d = M2;
            if (req)  pending_d = 1'b1;
         end
         M2: begin
            if (xfer) state_d = M3;
            if (req)  pending_d = 1'b1;
         end
         M3: begin
            if (xfer) state_d = M4;
            if (req)  pending_d = 1'b1;
         end
         M4: begin
            if (xfer) begin
               done_d    = 1'b1;
               pending_d = 1'b0;
               // A request on this very edge chains the next frame too.
               if (pending_q || req) begin
                  snap_d  = motor_in;
                  state_d = HDR;
               end else begin
                  state_d = IDLE;
               end
            end else if (req) begin
               pending_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are derived from the next state.
      out_valid_d = (state_d != IDLE);
      busy_d      = (state_d != IDLE);
      case (state_d)
         HDR:     serial_d = HEADER;
         M1:      serial_d = snap_d[0];
         M2:      serial_d = snap_d[1];
         M3:      serial_d = snap_d[2];
         M4:      serial_d = snap_d[3];
         default: serial_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         snap_q      <= '{default: 8'h00};
         pending_q   <= 1'b0;
         serial_q    <= 8'h00;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         pending_q   <= pending_d;
         serial_q    <= serial_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign serial    = serial_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
